// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse stretcher.
//   state_t : FSM state encoding (IDLE, HIGH, LOW)
//   max_u   : constant-foldable maximum, used to size the cycle timer
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_stretcher_cycle_timer.sv
// cycle_timer: loadable down-counter with a done flag.
// Ports:
//   clk      : clock, posedge
//   reset    : synchronous, active-low
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load; done asserts load_val+1 edges after the load
//   done     : count has reached zero
module cycle_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event strobes into held levels of
// HOLD_CYCLES high followed by at least GAP_CYCLES low, queuing up to
// MAX_PENDING events that arrive while a level is being emitted.
// Ports:
//   clk      : clock, posedge
//   reset    : synchronous, active-low
//   pulseIn  : event strobe, one event per cycle sampled high
//   levelOut : stretched level (registered)
//   busy     : FSM not idle (registered)
//   pending  : queued, not-yet-emitted events
//   dropped  : one-cycle strobe, an event was lost to saturation
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter  int unsigned HOLD_CYCLES = 4,
  parameter  int unsigned GAP_CYCLES  = 2,
  parameter  int unsigned MAX_PENDING = 3,
  localparam int unsigned PW          = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pulseIn,
  output logic          levelOut,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          dropped
);

  localparam int unsigned CW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
  // Timer is loaded with N-1 so the state's final edge is the one that sees done.
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_PENDING);

  state_t          state, state_n;
  logic            tmr_load;
  logic [CW-1:0]   tmr_val;
  logic            tmr_done;
  logic            start;
  logic            want;
  logic [PW-1:0]   pending_n;
  logic            dropped_n;

  cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign want = pulseIn || (pending != '0);

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      IDLE: begin
        if (want) begin
          state_n  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      HIGH: begin
        if (tmr_done) begin
          state_n  = LOW;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      LOW: begin
        if (tmr_done) begin
          if (want) begin
            state_n  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign start = (state_n == HIGH) && (state != HIGH);

  // A start serves the oldest queued event first; a same-cycle pulse then
  // takes its queue slot, so the count is net unchanged.
  always_comb begin
    pending_n = pending;
    dropped_n = 1'b0;
    if (start) begin
      if (pending != '0) begin
        pending_n = pending - PW'(1) + PW'(pulseIn);
      end
    end else if (pulseIn) begin
      if (pending < MAX_P) begin
        pending_n = pending + PW'(1);
      end else begin
        dropped_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      levelOut <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_n;
      levelOut <= (state_n == HIGH);
      busy     <= (state_n != IDLE);
      pending  <= pending_n;
      dropped  <= dropped_n;
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  localparam int unsigned PW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          pulseIn;
  logic          levelOut;
  logic          busy;
  logic [PW-1:0] pending;
  logic          dropped;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [4:0] exp_q[$];
  int         cnt_q[$];

  pulse_stretcher #(
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .MAX_PENDING (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pulseIn  (pulseIn),
    .levelOut (levelOut),
    .busy     (busy),
    .pending  (pending),
    .dropped  (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic pin, input logic rst);
    pulseIn = pin;
    reset   = rst;
    @(posedge clk);
    #1;
  endtask

  // Push expected {levelOut,busy,pending,dropped}, clock, then pop and compare.
  task automatic chk(input string tag, input logic pin, input logic rst,
                     input logic l, input logic b, input logic [PW-1:0] p, input logic d);
    logic [4:0] got;
    logic [4:0] exp;
    exp_q.push_back({l, b, p, d});
    tick(pin, rst);
    got = {levelOut, busy, pending, dropped};
    exp = exp_q.pop_front();
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed l/b/p/d=%b expected %b", tag, got, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int got);
    int exp;
    exp = cnt_q.pop_front();
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int events, falls, drops, budget, gap;
    logic prev;

    reset   = 1'b0;
    pulseIn = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Reset dominates pulseIn, then stays idle after release
    for (int k = 0; k < 3; k++) chk("reset_hold", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 3; k++) chk("reset_rel", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // Single pulse: 4 high, 2 low, then idle
    for (int k = 0; k < 8; k++)
      chk("single", (k == 0), 1'b1, (k < 4), (k < 6), 2'd0, 1'b0);

    // Five consecutive pulses: queue saturates at 3, fifth is dropped
    for (int k = 0; k < 30; k++) begin
      logic [PW-1:0] p;
      p = (k < 4) ? PW'(k) : (k < 6) ? 2'd3 : (k < 12) ? 2'd2 : (k < 18) ? 2'd1 : 2'd0;
      chk("burst5", (k < 5), 1'b1, (k < 24) && ((k % 6) < 4), (k < 24), p, (k == 4));
    end

    // Pulse on the final LOW edge restarts HIGH directly with nothing queued
    for (int k = 0; k < 14; k++)
      chk("low_edge", (k == 0) || (k == 6), 1'b1, (k < 10) && ((k % 6) < 4), (k < 12), 2'd0, 1'b0);

    // Reset mid-operation discards the active and queued events
    for (int k = 0; k < 3; k++) chk("pre_rst", 1'b1, 1'b1, 1'b1, 1'b1, PW'(k), 1'b0);
    chk("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 10; k++) chk("post_rst", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);

    // Release-detecting consumer, sparse random events: nothing may be lost
    events = 0; falls = 0; drops = 0; prev = levelOut;
    for (int e = 0; e < 20; e++) begin
      gap = $urandom_range(9, 6);
      for (int c = 0; c < gap; c++) begin
        tick((c == 0), 1'b1);
        if (c == 0) events++;
        if (prev && !levelOut) falls++;
        if (dropped) drops++;
        prev = levelOut;
      end
    end
    budget = 100;
    while (busy && budget > 0) begin
      tick(1'b0, 1'b1);
      if (prev && !levelOut) falls++;
      if (dropped) drops++;
      prev = levelOut;
      budget--;
    end
    cnt_q.push_back(1);
    cmp_int("sparse_drain", int'(!busy));
    cnt_q.push_back(0);
    cmp_int("sparse_drops", drops);
    cnt_q.push_back(events);
    cmp_int("sparse_consumer", falls);

    // Dense random events: releases seen == events minus drops, and drops occur
    tick(1'b0, 1'b0);
    events = 0; falls = 0; drops = 0; prev = levelOut;
    for (int e = 0; e < 10; e++) begin
      gap = $urandom_range(3, 1);
      for (int c = 0; c < gap; c++) begin
        tick((c == 0), 1'b1);
        if (c == 0) events++;
        if (prev && !levelOut) falls++;
        if (dropped) drops++;
        prev = levelOut;
      end
    end
    budget = 100;
    while (busy && budget > 0) begin
      tick(1'b0, 1'b1);
      if (prev && !levelOut) falls++;
      if (dropped) drops++;
      prev = levelOut;
      budget--;
    end
    cnt_q.push_back(1);
    cmp_int("dense_drain", int'(!busy));
    cnt_q.push_back(1);
    cmp_int("dense_drops_seen", int'(drops >= 2));
    cnt_q.push_back(events - drops);
    cmp_int("dense_consumer", falls);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
